decode_ctrl_seq: RTL

Multi-cycle control sequencer in front of the decode unit. It accepts 32-bit instructions from instruction memory over a valid/ready handshake and registers each one. It classifies the opcode and pulses exactly one instruction-type enable (I/R/S/SB/U/UJ) for one cycle. It then waits for execute completion, issues writeback/PC-increment pulses, and traps on illegal opcodes or execute timeout.

---
 rtl/atom_ctrl_pkg.sv | 63 ++++++
 rtl/instr_type_classify.sv | 22 ++
 rtl/decode_ctrl_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/atom_ctrl_pkg.sv
// Shared types and encodings for the decode control sequencer.
package atom_ctrl_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned NUM_EN  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        IT_I,
        IT_R,
        IT_S,
        IT_SB,
        IT_U,
        IT_UJ,
        IT_ILLEGAL
    } instr_type_t;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'b10;

    // Enable vector order: {I, R, S, SB, U, UJ}; illegal maps to all-zero.
    function automatic logic [NUM_EN-1:0] type_onehot(input instr_type_t t);
        logic [NUM_EN-1:0] v;
        v = '0;
        case (t)
            IT_I:    v = 6'b100000;
            IT_R:    v = 6'b010000;
            IT_S:    v = 6'b001000;
            IT_SB:   v = 6'b000100;
            IT_U:    v = 6'b000010;
            IT_UJ:   v = 6'b000001;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Stores and branches have no destination register.
    function automatic logic writes_rd(input instr_type_t t);
        return (t == IT_I) || (t == IT_R) || (t == IT_U) || (t == IT_UJ);
    endfunction

endpackage

// File: rtl/instr_type_classify.sv
// Combinational opcode-to-instruction-type classifier.
module instr_type_classify
    import atom_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output instr_type_t      type_o
);

    always_comb begin
        type_o = IT_ILLEGAL;
        case (opcode_i)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: type_o = IT_I;
            OPC_OP:                         type_o = IT_R;
            OPC_STORE:                      type_o = IT_S;
            OPC_BRANCH:                     type_o = IT_SB;
            OPC_LUI, OPC_AUIPC:             type_o = IT_U;
            OPC_JAL:                        type_o = IT_UJ;
            default:                        type_o = IT_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_seq.sv
// Fetch/decode/execute/writeback control sequencer with illegal-opcode and timeout traps.
module decode_ctrl_seq
    import atom_ctrl_pkg::*;
#(
    parameter int unsigned EX_TIMEOUT = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 instr_valid_i,
    input  logic [INSTR_W-1:0]   instr_i,
    output logic                 instr_ready_o,
    output logic [INSTR_W-1:0]   instr_o,
    output logic                 I_EN_o,
    output logic                 R_EN_o,
    output logic                 S_EN_o,
    output logic                 SB_EN_o,
    output logic                 U_EN_o,
    output logic                 UJ_EN_o,
    input  logic                 ex_done_i,
    output logic                 wb_en_o,
    output logic                 pc_inc_o,
    output logic                 busy_o,
    output logic                 trap_o,
    output logic [CAUSE_W-1:0]   trap_cause_o,
    input  logic                 trap_clr_i
);

    state_t              r_state, w_state_nxt;
    instr_type_t         r_type, w_type_nxt, w_cls;
    logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [NUM_EN-1:0]   r_en, w_en_nxt;
    logic                r_wb, w_wb_nxt;
    logic                r_pc, w_pc_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_trap, w_trap_nxt;
    logic [CAUSE_W-1:0]  r_cause, w_cause_nxt;

    instr_type_classify u_classify (
        .opcode_i (instr_i[OPC_W-1:0]),
        .type_o   (w_cls)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_type  <= IT_ILLEGAL;
            r_instr <= '0;
            r_cnt   <= '0;
            r_en    <= '0;
            r_wb    <= 1'b0;
            r_pc    <= 1'b0;
            r_busy  <= 1'b0;
            r_trap  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_type  <= w_type_nxt;
            r_instr <= w_instr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
            r_wb    <= w_wb_nxt;
            r_pc    <= w_pc_nxt;
            r_busy  <= w_busy_nxt;
            r_trap  <= w_trap_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Pulses are computed on the transition into the state they belong to.
    always_comb begin
        w_state_nxt = r_state;
        w_type_nxt  = r_type;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = '0;
        w_wb_nxt    = 1'b0;
        w_pc_nxt    = 1'b0;
        w_trap_nxt  = r_trap;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_IDLE: begin
                if (en_i) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid_i) begin
                    w_instr_nxt = instr_i;
                    w_type_nxt  = w_cls;
                    w_en_nxt    = type_onehot(w_cls);
                    w_state_nxt = ST_DECODE;
                end else if (!en_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (r_type == IT_ILLEGAL) begin
                    w_state_nxt = ST_TRAP;
                    w_trap_nxt  = 1'b1;
                    w_cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_nxt   = '0;
                end
            end
            ST_EXEC: begin
                if (ex_done_i) begin
                    w_state_nxt = ST_WB;
                    w_wb_nxt    = writes_rd(r_type);
                    w_pc_nxt    = 1'b1;
                end else if (r_cnt == CNT_W'(EX_TIMEOUT - 1)) begin
                    w_state_nxt = ST_TRAP;
                    w_trap_nxt  = 1'b1;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WB: begin
                w_state_nxt = en_i ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                if (trap_clr_i) begin
                    w_state_nxt = ST_IDLE;
                    w_trap_nxt  = 1'b0;
                    w_cause_nxt = CAUSE_NONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_TRAP);
    end

    assign instr_ready_o = (r_state == ST_FETCH);
    assign instr_o       = r_instr;
    assign {I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o} = r_en;
    assign wb_en_o       = r_wb;
    assign pc_inc_o      = r_pc;
    assign busy_o        = r_busy;
    assign trap_o        = r_trap;
    assign trap_cause_o  = r_cause;

endmodule
